tilelink_ul_buffer: RTL and testbench

Single-clock TL-UL buffer that decouples a master port from a slave port. Channel A (master→slave) and Channel D (slave→master) each get an independently sized synchronous FIFO. The block tracks in-flight source IDs so that no two outstanding requests share a source, and it flags Channel D responses that arrive without a matching request. It sits in the 100 MHz fabric between a TL-UL master and a slave or CDC adapter, and replaces ad-hoc register slices.

---
 rtl/tl_ul_pkg.sv | 56 +++++
 rtl/tilelink_ul_buffer_if.sv | 57 +++++
 rtl/tl_sync_fifo.sv | 94 +++++++++
 rtl/tilelink_ul_buffer.sv | 190 +++++++++++++++++++
 tb/tb_tilelink_ul_buffer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_ul_pkg.sv
// -----------------------------------------------------------------------------
// tl_ul_pkg
// Shared TL-UL definitions for the tilelink_ul_buffer slice:
//   - default field widths
//   - Channel A / Channel D opcode encodings
//   - CH_A_WIDTH / CH_D_WIDTH: width of a channel beat packed MSB..LSB in
//     field order (the valid bit is never packed)
// -----------------------------------------------------------------------------
package tl_ul_pkg;

  localparam int unsigned TL_ADDR_WIDTH   = 32;
  localparam int unsigned TL_DATA_WIDTH   = 32;
  localparam int unsigned TL_MASK_WIDTH   = TL_DATA_WIDTH / 8;
  localparam int unsigned TL_SIZE_WIDTH   = 3;
  localparam int unsigned TL_SRC_WIDTH    = 2;
  localparam int unsigned TL_SINK_WIDTH   = 1;
  localparam int unsigned TL_OPCODE_WIDTH = 3;
  localparam int unsigned TL_PARAM_WIDTH  = 3;

  typedef enum logic [2:0] {
    TL_A_PUT_FULL_DATA    = 3'd0,
    TL_A_PUT_PARTIAL_DATA = 3'd1,
    TL_A_GET              = 3'd4
  } tl_a_opcode_e;

  typedef enum logic [2:0] {
    TL_D_ACCESS_ACK      = 3'd0,
    TL_D_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  // {opcode, param, size, source, address, mask, data}
  function automatic int unsigned CH_A_WIDTH(
    input int unsigned opcode_w,
    input int unsigned param_w,
    input int unsigned size_w,
    input int unsigned src_w,
    input int unsigned addr_w,
    input int unsigned mask_w,
    input int unsigned data_w
  );
    return opcode_w + param_w + size_w + src_w + addr_w + mask_w + data_w;
  endfunction

  // {opcode, param, size, source, sink, data, error}
  function automatic int unsigned CH_D_WIDTH(
    input int unsigned opcode_w,
    input int unsigned param_w,
    input int unsigned size_w,
    input int unsigned src_w,
    input int unsigned sink_w,
    input int unsigned data_w
  );
    return opcode_w + param_w + size_w + src_w + sink_w + data_w + 1;
  endfunction

endpackage

// File: rtl/tilelink_ul_buffer_if.sv
// -----------------------------------------------------------------------------
// tilelink_ul_buffer_if
// One TL-UL link (Channel A and Channel D) between a master and a slave.
//   modport master : drives Channel A, receives Channel D
//   modport slave  : receives Channel A, drives Channel D
// Parameters mirror the TL-UL field widths of tl_ul_pkg.
// -----------------------------------------------------------------------------
interface tilelink_ul_buffer_if
  import tl_ul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = TL_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = TL_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = TL_SIZE_WIDTH,
  parameter int unsigned SRC_WIDTH    = TL_SRC_WIDTH,
  parameter int unsigned SINK_WIDTH   = TL_SINK_WIDTH,
  parameter int unsigned OPCODE_WIDTH = TL_OPCODE_WIDTH,
  parameter int unsigned PARAM_WIDTH  = TL_PARAM_WIDTH
);

  // Channel A
  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [PARAM_WIDTH-1:0]  a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic [SRC_WIDTH-1:0]    a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MASK_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;

  // Channel D
  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [PARAM_WIDTH-1:0]  d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic [SRC_WIDTH-1:0]    d_source;
  logic [SINK_WIDTH-1:0]   d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  d_ready
  );

endinterface

// File: rtl/tl_sync_fifo.sv
// -----------------------------------------------------------------------------
// tl_sync_fifo
// Single-clock FIFO, DEPTH a power of two >= 2. The head entry is presented
// directly on rdata (no output register), so a push at edge N is visible
// after edge N. No write-through: a full FIFO ignores push even when it pops
// in the same cycle. Storage is cleared by reset.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   push / wdata       write request and payload
//   pop                read request (ignored when empty)
//   rdata              head entry
//   full / empty       status
//   count              occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module tl_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q,  count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);  // wraps DEPTH-1 -> 0
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is reset along with the pointers so the payload outputs
  // read as zero out of reset instead of whatever the array powered up with.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tilelink_ul_buffer.sv
// -----------------------------------------------------------------------------
// tilelink_ul_buffer
// TL-UL buffer decoupling a master port from a slave port with one FIFO per
// channel. Optional source tracking (macro TL_BUF_SRC_TRACK_EN) keeps at most
// one outstanding request per source ID: an A head whose source is already in
// flight is held (no reordering), and a D response for a source that is not
// in flight raises the sticky err_unexpected_d while still being forwarded.
// Without the macro no tracking logic is built and inflight /
// err_unexpected_d read 0.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   up_if (slave)       link to the master: A in, D out
//   dn_if (master)      link to the slave:  A out, D in
//   a_count, d_count    FIFO occupancies
//   inflight            one bit per source with a request outstanding
//   err_unexpected_d    sticky unexpected-response flag
// Both ready outputs stay low until the first clock edge after reset release.
// -----------------------------------------------------------------------------
module tilelink_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = TL_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = TL_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = TL_SIZE_WIDTH,
  parameter int unsigned SRC_WIDTH    = TL_SRC_WIDTH,
  parameter int unsigned SINK_WIDTH   = TL_SINK_WIDTH,
  parameter int unsigned OPCODE_WIDTH = TL_OPCODE_WIDTH,
  parameter int unsigned PARAM_WIDTH  = TL_PARAM_WIDTH,
  parameter int unsigned A_DEPTH      = 4,
  parameter int unsigned D_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  tilelink_ul_buffer_if.slave        up_if,
  tilelink_ul_buffer_if.master       dn_if,
  output logic [$clog2(A_DEPTH):0]   a_count,
  output logic [$clog2(D_DEPTH):0]   d_count,
  output logic [2**SRC_WIDTH-1:0]    inflight,
  output logic                       err_unexpected_d
);

  localparam int unsigned A_W = CH_A_WIDTH(OPCODE_WIDTH, PARAM_WIDTH, SIZE_WIDTH,
                                           SRC_WIDTH, ADDR_WIDTH, MASK_WIDTH, DATA_WIDTH);
  localparam int unsigned D_W = CH_D_WIDTH(OPCODE_WIDTH, PARAM_WIDTH, SIZE_WIDTH,
                                           SRC_WIDTH, SINK_WIDTH, DATA_WIDTH);

  logic [A_W-1:0] a_wdata, a_rdata;
  logic [D_W-1:0] d_wdata, d_rdata;
  logic           a_full, a_empty, d_full, d_empty;
  logic           a_ready_in, d_ready_in;
  logic           a_valid_out, d_valid_out;
  logic           a_fire_in, a_fire_out, d_fire_in, d_fire_out;
  logic           init_done_q, init_done_d;

  // ---------------------------------------------------------------------------
  // Init gate: readiness is withheld for the first edge after reset release.
  // ---------------------------------------------------------------------------
  always_comb begin
    init_done_d = init_done_q;
    if (!init_done_q) begin
      init_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign a_ready_in  = !a_full && init_done_q;
  assign d_ready_in  = !d_full && init_done_q;
  assign d_valid_out = !d_empty;

  assign a_fire_in  = up_if.a_valid && a_ready_in;
  assign a_fire_out = a_valid_out && dn_if.a_ready;
  assign d_fire_in  = dn_if.d_valid && d_ready_in;
  assign d_fire_out = d_valid_out && up_if.d_ready;

  assign up_if.a_ready = a_ready_in;
  assign dn_if.a_valid = a_valid_out;
  assign dn_if.d_ready = d_ready_in;
  assign up_if.d_valid = d_valid_out;

  // ---------------------------------------------------------------------------
  // Channel A FIFO (master -> slave)
  // ---------------------------------------------------------------------------
  assign a_wdata = {up_if.a_opcode, up_if.a_param, up_if.a_size, up_if.a_source,
                    up_if.a_address, up_if.a_mask, up_if.a_data};
  assign {dn_if.a_opcode, dn_if.a_param, dn_if.a_size, dn_if.a_source,
          dn_if.a_address, dn_if.a_mask, dn_if.a_data} = a_rdata;

  tl_sync_fifo #(
    .WIDTH (A_W),
    .DEPTH (A_DEPTH)
  ) u_a_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (a_fire_in),
    .pop     (a_fire_out),
    .wdata   (a_wdata),
    .rdata   (a_rdata),
    .full    (a_full),
    .empty   (a_empty),
    .count   (a_count)
  );

  // ---------------------------------------------------------------------------
  // Channel D FIFO (slave -> master)
  // ---------------------------------------------------------------------------
  assign d_wdata = {dn_if.d_opcode, dn_if.d_param, dn_if.d_size, dn_if.d_source,
                    dn_if.d_sink, dn_if.d_data, dn_if.d_error};
  assign {up_if.d_opcode, up_if.d_param, up_if.d_size, up_if.d_source,
          up_if.d_sink, up_if.d_data, up_if.d_error} = d_rdata;

  tl_sync_fifo #(
    .WIDTH (D_W),
    .DEPTH (D_DEPTH)
  ) u_d_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (d_fire_in),
    .pop     (d_fire_out),
    .wdata   (d_wdata),
    .rdata   (d_rdata),
    .full    (d_full),
    .empty   (d_empty),
    .count   (d_count)
  );

  // ---------------------------------------------------------------------------
  // Source tracking
  // ---------------------------------------------------------------------------
`ifdef TL_BUF_SRC_TRACK_EN
  localparam int unsigned NUM_SRC    = 2**SRC_WIDTH;
  localparam int unsigned A_SRC_LSB  = ADDR_WIDTH + MASK_WIDTH + DATA_WIDTH;

  logic [NUM_SRC-1:0]   inflight_q, inflight_d;
  logic                 err_q, err_d;
  logic [SRC_WIDTH-1:0] a_head_source;
  logic [SRC_WIDTH-1:0] d_in_source;

  assign a_head_source = a_rdata[A_SRC_LSB +: SRC_WIDTH];
  assign d_in_source   = dn_if.d_source;

  // The head blocks the whole queue while its source is outstanding.
  assign a_valid_out = !a_empty && !inflight_q[a_head_source];

  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (d_fire_in) begin
      if (!inflight_q[d_in_source]) begin
        err_d = 1'b1;
      end
      inflight_d[d_in_source] = 1'b0;
    end
    // A head can only issue while its own bit is clear, so a same-cycle
    // clear on that source is itself an unexpected response; the new
    // request wins and stays outstanding.
    if (a_fire_out) begin
      inflight_d[a_head_source] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight         = inflight_q;
  assign err_unexpected_d = err_q;
`else
  assign a_valid_out      = !a_empty;
  assign inflight         = '0;
  assign err_unexpected_d = 1'b0;
`endif

endmodule

// File: tb/tb_tilelink_ul_buffer.sv
module tb_tilelink_ul_buffer;
  import tl_ul_pkg::*;

  localparam int unsigned A_DEPTH = 4;
  localparam int unsigned D_DEPTH = 4;
`ifdef TL_BUF_SRC_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [0:0]  sink;
    logic [31:0] data;
    logic        error;
  } d_beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tilelink_ul_buffer_if up_if ();
  tilelink_ul_buffer_if dn_if ();

  logic [2:0] a_count, d_count;
  logic [3:0] inflight;
  logic       err_unexpected_d;

  tilelink_ul_buffer #(
    .A_DEPTH (A_DEPTH),
    .D_DEPTH (D_DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .up_if            (up_if),
    .dn_if            (dn_if),
    .a_count          (a_count),
    .d_count          (d_count),
    .inflight         (inflight),
    .err_unexpected_d (err_unexpected_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: two queues, a set of outstanding sources, a sticky flag.
  // ---------------------------------------------------------------------------
  a_beat_t  aq[$];
  d_beat_t  dq[$];
  bit [3:0] m_inflight;
  bit       m_err;
  bit       m_init;

  function automatic bit m_a_ready();
    return m_init && (aq.size() < int'(A_DEPTH));
  endfunction

  function automatic bit m_d_ready();
    return m_init && (dq.size() < int'(D_DEPTH));
  endfunction

  function automatic bit m_a_valid();
    if (aq.size() == 0) return 1'b0;
    return !(TRACK && m_inflight[aq[0].source]);
  endfunction

  function automatic a_beat_t in_a();
    return {up_if.a_opcode, up_if.a_param, up_if.a_size, up_if.a_source,
            up_if.a_address, up_if.a_mask, up_if.a_data};
  endfunction

  function automatic d_beat_t in_d();
    return {dn_if.d_opcode, dn_if.d_param, dn_if.d_size, dn_if.d_source,
            dn_if.d_sink, dn_if.d_data, dn_if.d_error};
  endfunction

  function automatic a_beat_t out_a();
    return {dn_if.a_opcode, dn_if.a_param, dn_if.a_size, dn_if.a_source,
            dn_if.a_address, dn_if.a_mask, dn_if.a_data};
  endfunction

  function automatic d_beat_t out_d();
    return {up_if.d_opcode, up_if.d_param, up_if.d_size, up_if.d_source,
            up_if.d_sink, up_if.d_data, up_if.d_error};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aq.delete();
      dq.delete();
      m_inflight = '0;
      m_err      = 1'b0;
      m_init     = 1'b0;
    end else begin
      bit      a_in, a_out, d_in, d_out;
      a_beat_t na;
      d_beat_t nd;
      a_in  = up_if.a_valid && m_a_ready();
      a_out = m_a_valid() && dn_if.a_ready;
      d_in  = dn_if.d_valid && m_d_ready();
      d_out = (dq.size() != 0) && up_if.d_ready;
      na    = in_a();
      nd    = in_d();
      if (d_in) begin
        if (!m_inflight[nd.source]) m_err = 1'b1;
        m_inflight[nd.source] = 1'b0;
      end
      if (a_out) begin
        m_inflight[aq[0].source] = 1'b1;
        void'(aq.pop_front());
      end
      if (a_in)  aq.push_back(na);
      if (d_out) void'(dq.pop_front());
      if (d_in)  dq.push_back(nd);
      m_init = 1'b1;
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    check("a_ready_in",  up_if.a_ready, m_a_ready());
    check("a_valid_out", dn_if.a_valid, m_a_valid());
    check("d_ready_in",  dn_if.d_ready, m_d_ready());
    check("d_valid_out", up_if.d_valid, dq.size() != 0);
    check("a_count",     a_count, aq.size());
    check("d_count",     d_count, dq.size());
    check("inflight",    inflight, TRACK ? m_inflight : 4'b0);
    check("err_unexpected_d", err_unexpected_d, TRACK ? m_err : 1'b0);
    if (aq.size() != 0) check("a_head", out_a(), aq[0]);
    if (dq.size() != 0) check("d_head", out_d(), dq[0]);
  end

  // Log of beats actually delivered on each output side.
  logic [31:0] a_log[$];
  logic [31:0] d_log[$];
  always @(negedge clk) begin
    if (dn_if.a_valid && dn_if.a_ready) a_log.push_back(dn_if.a_address);
    if (up_if.d_valid && up_if.d_ready) d_log.push_back(up_if.d_data);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #5;
  endtask

  function automatic a_beat_t mk_get(input logic [1:0] src, input logic [31:0] addr);
    a_beat_t b;
    b.opcode  = TL_A_GET;
    b.param   = 3'd0;
    b.size    = 3'd2;
    b.source  = src;
    b.address = addr;
    b.mask    = 4'hF;
    b.data    = 32'h0;
    return b;
  endfunction

  function automatic d_beat_t mk_d(input logic [2:0] op, input logic [1:0] src,
                                   input logic [31:0] data);
    d_beat_t b;
    b.opcode = op;
    b.param  = 3'd0;
    b.size   = 3'd2;
    b.source = src;
    b.sink   = 1'b0;
    b.data   = data;
    b.error  = 1'b0;
    return b;
  endfunction

  task automatic drive_a(input bit v, input a_beat_t b);
    up_if.a_valid   = v;
    up_if.a_opcode  = b.opcode;
    up_if.a_param   = b.param;
    up_if.a_size    = b.size;
    up_if.a_source  = b.source;
    up_if.a_address = b.address;
    up_if.a_mask    = b.mask;
    up_if.a_data    = b.data;
  endtask

  task automatic drive_d(input bit v, input d_beat_t b);
    dn_if.d_valid  = v;
    dn_if.d_opcode = b.opcode;
    dn_if.d_param  = b.param;
    dn_if.d_size   = b.size;
    dn_if.d_source = b.source;
    dn_if.d_sink   = b.sink;
    dn_if.d_data   = b.data;
    dn_if.d_error  = b.error;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    drive_a(1'b0, '0);
    drive_d(1'b0, '0);
    dn_if.a_ready = 1'b0;
    up_if.d_ready = 1'b0;
    reset_n = 1'b0;

    // Reset: every output 0.
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_ready_in",  up_if.a_ready, 1'b0);
    check("rst_d_ready_in",  dn_if.d_ready, 1'b0);
    check("rst_a_valid_out", dn_if.a_valid, 1'b0);
    check("rst_d_valid_out", up_if.d_valid, 1'b0);
    check("rst_a_count",     a_count, 3'd0);
    check("rst_d_count",     d_count, 3'd0);
    check("rst_inflight",    inflight, 4'd0);
    check("rst_err",         err_unexpected_d, 1'b0);
    check("rst_a_address",   dn_if.a_address, 32'h0);
    check("rst_d_data",      up_if.d_data, 32'h0);

    // Release: ready only after the next edge.
    tick();
    reset_n = 1'b1;
    look();
    check("init_a_ready_lo", up_if.a_ready, 1'b0);
    tick();
    look();
    check("init_a_ready_hi", up_if.a_ready, 1'b1);
    check("init_d_ready_hi", dn_if.d_ready, 1'b1);
    check("init_a_count",    a_count, 3'd0);
    tick();

    // Fill Channel A with 4 Gets while the slave is not ready.
    a_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, mk_get(2'(i), 32'h1000 + 32'(4 * i)));
      tick();
    end
    drive_a(1'b1, mk_get(2'd0, 32'h1010));
    look();
    check("full_a_count",    a_count, 3'd4);
    check("full_a_ready_in", up_if.a_ready, 1'b0);
    tick();
    look();
    check("fifth_held_count", a_count, 3'd4);
    tick();
    drive_a(1'b0, '0);
    dn_if.a_ready = 1'b1;
    repeat (5) tick();
    dn_if.a_ready = 1'b0;
    look();
    check("drain_a_count", a_count, 3'd0);
    check("drain_n_beats", a_log.size(), 4);
    for (int i = 0; i < a_log.size(); i++)
      check("drain_order", a_log[i], 32'h1000 + 32'(4 * i));
    check("drain_inflight", inflight, TRACK ? 4'hF : 4'h0);
    tick();

    // Responses for sources 0..3.
    d_log.delete();
    up_if.d_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      drive_d(1'b1, mk_d(TL_D_ACCESS_ACK_DATA, 2'(s), 32'hD000_0000 + 32'(s)));
      tick();
    end
    drive_d(1'b0, '0);
    repeat (2) tick();
    look();
    check("resp_inflight", inflight, 4'h0);
    check("resp_err",      err_unexpected_d, 1'b0);
    check("resp_n_beats",  d_log.size(), 4);
    for (int i = 0; i < d_log.size(); i++)
      check("resp_order", d_log[i], 32'hD000_0000 + 32'(i));
    tick();

    // Same-source stall.
    a_log.delete();
    dn_if.a_ready = 1'b1;
    drive_a(1'b1, mk_get(2'd1, 32'h2000));
    tick();
    drive_a(1'b1, mk_get(2'd1, 32'h2004));
    tick();
    drive_a(1'b0, '0);
    dn_if.a_ready = 1'b0;
    repeat (2) tick();
    look();
    check("stall_a_valid",  dn_if.a_valid, !TRACK);
    check("stall_a_count",  a_count, 3'd1);
    check("stall_inflight", inflight, TRACK ? 4'b0010 : 4'b0000);
    tick();
    drive_d(1'b1, mk_d(TL_D_ACCESS_ACK_DATA, 2'd1, 32'hD1D1_0001));
    look();
    check("stall_hold_a_valid", dn_if.a_valid, !TRACK);
    tick();
    drive_d(1'b0, '0);
    look();
    check("release_a_valid", dn_if.a_valid, 1'b1);
    tick();
    dn_if.a_ready = 1'b1;
    tick();
    dn_if.a_ready = 1'b0;
    tick();
    look();
    check("stall_n_beats", a_log.size(), 2);
    if (a_log.size() == 2) begin
      check("stall_first",  a_log[0], 32'h2000);
      check("stall_second", a_log[1], 32'h2004);
    end
    check("reissue_inflight", inflight, TRACK ? 4'b0010 : 4'b0000);
    tick();
    drive_d(1'b1, mk_d(TL_D_ACCESS_ACK_DATA, 2'd1, 32'hD1D1_0002));
    tick();
    drive_d(1'b0, '0);
    repeat (2) tick();

    // Unexpected response on source 2.
    up_if.d_ready = 1'b0;
    drive_d(1'b1, mk_d(TL_D_ACCESS_ACK, 2'd2, 32'hCAFE_0002));
    tick();
    drive_d(1'b0, '0);
    look();
    check("unexp_err",     err_unexpected_d, TRACK);
    check("unexp_d_valid", up_if.d_valid, 1'b1);
    check("unexp_d_data",  up_if.d_data, 32'hCAFE_0002);
    check("unexp_d_src",   up_if.d_source, 2'd2);
    check("unexp_d_op",    up_if.d_opcode, 3'd0);
    d_log.delete();
    tick();
    up_if.d_ready = 1'b1;
    repeat (3) tick();
    look();
    check("unexp_err_sticky", err_unexpected_d, TRACK);
    check("unexp_n_beats",    d_log.size(), 1);
    if (d_log.size() == 1) check("unexp_delivered", d_log[0], 32'hCAFE_0002);
    tick();

    // Streaming: push and pop every cycle across pointer wrap.
    a_log.delete();
    dn_if.a_ready = 1'b0;
    drive_a(1'b1, mk_get(2'd0, 32'h3000));
    tick();
    drive_a(1'b1, mk_get(2'd1, 32'h3004));
    tick();
    dn_if.a_ready = 1'b1;
    for (int j = 0; j < 23; j++) begin
      if (j < 20) drive_a(1'b1, mk_get(2'((j + 2) % 4), 32'h3000 + 32'(4 * (j + 2))));
      else        drive_a(1'b0, '0);
      if (j >= 1) drive_d(1'b1, mk_d(TL_D_ACCESS_ACK_DATA, 2'((j - 1) % 4), 32'hE000_0000 + 32'(j)));
      else        drive_d(1'b0, '0);
      if (j >= 1 && j < 20) begin
        look();
        check("stream_a_count", a_count, 3'd2);
      end
      tick();
    end
    drive_d(1'b0, '0);
    dn_if.a_ready = 1'b0;
    repeat (2) tick();
    look();
    check("stream_n_beats", a_log.size(), 22);
    for (int i = 0; i < a_log.size(); i++)
      check("stream_order", a_log[i], 32'h3000 + 32'(4 * i));
    check("stream_inflight", inflight, 4'h0);
    tick();

    // Reset mid-transfer: 3 beats buffered, source 0 outstanding.
    dn_if.a_ready = 1'b1;
    drive_a(1'b1, mk_get(2'd0, 32'h4000));
    tick();
    drive_a(1'b1, mk_get(2'd1, 32'h4004));
    tick();
    dn_if.a_ready = 1'b0;
    drive_a(1'b1, mk_get(2'd2, 32'h4008));
    tick();
    drive_a(1'b1, mk_get(2'd3, 32'h400C));
    tick();
    drive_a(1'b0, '0);
    look();
    check("pre_rst_a_count",  a_count, 3'd3);
    check("pre_rst_inflight", inflight, TRACK ? 4'b0001 : 4'b0000);
    a_log.delete();
    #1;
    reset_n = 1'b0;
    dn_if.a_ready = 1'b1;
    #1;
    check("midrst_a_count",  a_count, 3'd0);
    check("midrst_inflight", inflight, 4'd0);
    check("midrst_a_valid",  dn_if.a_valid, 1'b0);
    check("midrst_d_valid",  up_if.d_valid, 1'b0);
    check("midrst_a_ready",  up_if.a_ready, 1'b0);
    check("midrst_err",      err_unexpected_d, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    look();
    check("post_rst_a_valid", dn_if.a_valid, 1'b0);
    check("post_rst_a_count", a_count, 3'd0);
    check("post_rst_no_beat", a_log.size(), 0);
    dn_if.a_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
